// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Slot tags carry a fixed-width register field; narrower REG_AW values are zero-extended.
package fwd_pkg;

    localparam int NULL_REG_DEFAULT = 31;
    localparam int FWD_REGFILE      = 0;
    localparam int TAG_AW           = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rd;
        logic [TAG_AW-1:0] rt;
        logic              regwrite;
        logic              is_load;
        logic              is_store;
    } slot_tag_t;

    // A slot produces src when it is a live register writer of a real register.
    function automatic logic tag_writes(input slot_tag_t         t,
                                        input logic [TAG_AW-1:0] src,
                                        input logic [TAG_AW-1:0] null_reg);
        return t.valid && t.regwrite && (t.rd == src) && (t.rd != null_reg);
    endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Shift register of in-flight destination tags, slot 0 = EX, slot N_FWD = last writeback.
// Frozen by hold; a non-pushed cycle shifts in an all-zero bubble.
module fwd_tag_pipe
    import fwd_pkg::*;
#(
    parameter int N_FWD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  push_valid,
    input  slot_tag_t             push_tag,
    output slot_tag_t [N_FWD:0]   slots
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slots <= '0;
        end else if (!hold) begin
            for (int i = N_FWD; i > 0; i--) begin
                slots[i] <= slots[i-1];
            end
            slots[0] <= push_valid ? push_tag : '0;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forward-select, load-use stall and store-data forward generation for the integer pipeline.
// Selects are computed for the instruction leaving ID and registered so they arrive with it in EX.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int N_FWD      = 2,
    parameter int LOAD_READY = 2,
    parameter int NULL_REG   = NULL_REG_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [REG_AW-1:0]            id_rs,
    input  logic [REG_AW-1:0]            id_rt,
    input  logic                         id_uses_rs,
    input  logic                         id_uses_rt,
    input  logic [REG_AW-1:0]            id_rd,
    input  logic                         id_regwrite,
    input  logic                         id_is_load,
    input  logic                         id_is_store,
    input  logic                         hold,
    input  logic                         flush,
    output logic                         stall,
    output logic [$clog2(N_FWD+1)-1:0]   ex_fwd_a,
    output logic [$clog2(N_FWD+1)-1:0]   ex_fwd_b,
    output logic                         mem_store_fwd
);

    localparam int                SEL_W    = $clog2(N_FWD + 1);
    localparam logic [TAG_AW-1:0] NULL_TAG = TAG_AW'(NULL_REG);

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             load_block;
    } src_res_t;

    slot_tag_t [N_FWD:0] slots;
    slot_tag_t           id_tag;
    src_res_t            res_a;
    src_res_t            res_b;
    logic                push_valid;
    logic                store_fwd_next;
    logic                unused_slot_bits;

    // Walk oldest to youngest so the youngest producer overwrites any older one.
    // A producer sitting in the last slot retires this cycle and reads back from the register file.
    function automatic src_res_t resolve(input slot_tag_t [N_FWD:0] s,
                                         input logic [TAG_AW-1:0]  src,
                                         input logic               used);
        src_res_t r;
        r.sel        = SEL_W'(FWD_REGFILE);
        r.load_block = 1'b0;
        for (int j = N_FWD; j >= 0; j--) begin
            if (tag_writes(s[j], src, NULL_TAG)) begin
                r.sel        = (j < N_FWD) ? SEL_W'(j + 1) : SEL_W'(FWD_REGFILE);
                r.load_block = s[j].is_load && ((j + 1) < LOAD_READY);
            end
        end
        if (!used) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        id_tag          = '0;
        id_tag.valid    = 1'b1;
        id_tag.rd       = TAG_AW'(id_rd);
        id_tag.rt       = TAG_AW'(id_rt);
        id_tag.regwrite = id_regwrite;
        id_tag.is_load  = id_is_load;
        id_tag.is_store = id_is_store;
    end

    always_comb begin
        res_a = resolve(slots, TAG_AW'(id_rs), id_uses_rs);
        res_b = resolve(slots, TAG_AW'(id_rt), id_uses_rt);
    end

    // A flushed ID instruction never stalls: it becomes a bubble instead.
    assign stall      = id_valid && !flush && (res_a.load_block || res_b.load_block);
    assign push_valid = id_valid && !stall && !flush;

    assign store_fwd_next = slots[0].valid && slots[0].is_store
                         && tag_writes(slots[1], slots[0].rt, NULL_TAG);

    fwd_tag_pipe #(
        .N_FWD (N_FWD)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .push_valid (push_valid),
        .push_tag   (id_tag),
        .slots      (slots)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_fwd_a      <= '0;
            ex_fwd_b      <= '0;
            mem_store_fwd <= 1'b0;
        end else if (!hold) begin
            ex_fwd_a      <= push_valid ? res_a.sel : SEL_W'(FWD_REGFILE);
            ex_fwd_b      <= push_valid ? res_b.sel : SEL_W'(FWD_REGFILE);
            mem_store_fwd <= store_fwd_next;
        end
    end

    // Older slots keep fields (rt, is_store) that only slot 0 / slot 1 consult.
    assign unused_slot_bits = ^slots;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed literal scenarios followed by random traffic,
// all checked every cycle against a producer-distance model of the pipeline.
module tb_fwd_hazard_unit;

    localparam int N_FWD      = 2;
    localparam int LOAD_READY = 2;
    localparam int NULL_R     = 31;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       id_is_store;
    logic       hold;
    logic       flush;
    logic       stall;
    logic [1:0] ex_fwd_a;
    logic [1:0] ex_fwd_b;
    logic       mem_store_fwd;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .id_rd         (id_rd),
        .id_regwrite   (id_regwrite),
        .id_is_load    (id_is_load),
        .id_is_store   (id_is_store),
        .hold          (hold),
        .flush         (flush),
        .stall         (stall),
        .ex_fwd_a      (ex_fwd_a),
        .ex_fwd_b      (ex_fwd_b),
        .mem_store_fwd (mem_store_fwd)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every real instruction that entered EX is remembered with the advance count at entry;
    // its distance from EX is simply (advances since then).
    typedef struct {
        logic [4:0] rd;
        logic [4:0] rt;
        logic       rw;
        logic       ld;
        logic       st;
        int         adv;
    } rec_t;

    rec_t rec_q[$];
    int   adv_cnt    = 0;
    logic model_live = 1'b0;
    int   exp_a      = 0;
    int   exp_b      = 0;
    int   exp_sf     = 0;

    function automatic void find(input logic [4:0] src, input logic uses,
                                 output int sel, output logic blk);
        int   best;
        logic ld;
        best = 99;
        ld   = 1'b0;
        foreach (rec_q[k]) begin
            int d;
            d = adv_cnt - rec_q[k].adv;
            if (rec_q[k].rw && rec_q[k].rd == src && int'(src) != NULL_R && d < best) begin
                best = d;
                ld   = rec_q[k].ld;
            end
        end
        sel = 0;
        blk = 1'b0;
        if (uses && best <= N_FWD) begin
            sel = (best < N_FWD) ? best + 1 : 0;
            blk = ld && (best + 1 < LOAD_READY);
        end
    endfunction

    int   m_sa, m_sb;
    logic m_ba, m_bb, m_stall;

    always begin
        @(negedge clk);
        #3;
        if (model_live) begin
            find(id_rs, id_uses_rs, m_sa, m_ba);
            find(id_rt, id_uses_rt, m_sb, m_bb);
            m_stall = id_valid && !flush && (m_ba || m_bb);
            check("stall_model", int'(stall), int'(m_stall));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            rec_q.delete();
            adv_cnt    = 0;
            exp_a      = 0;
            exp_b      = 0;
            exp_sf     = 0;
            model_live = 1'b1;
        end else if (model_live && !hold) begin
            logic push, has_st;
            logic [4:0] st_rt;
            rec_t r;
            push   = id_valid && !m_stall && !flush;
            exp_a  = push ? m_sa : 0;
            exp_b  = push ? m_sb : 0;
            has_st = 1'b0;
            st_rt  = '0;
            foreach (rec_q[k]) begin
                if (rec_q[k].adv == adv_cnt && rec_q[k].st) begin
                    has_st = 1'b1;
                    st_rt  = rec_q[k].rt;
                end
            end
            exp_sf = 0;
            if (has_st) begin
                foreach (rec_q[k]) begin
                    if (rec_q[k].adv == adv_cnt - 1 && rec_q[k].rw && rec_q[k].rd == st_rt
                        && int'(st_rt) != NULL_R)
                        exp_sf = 1;
                end
            end
            adv_cnt++;
            if (push) begin
                r.rd  = id_rd;
                r.rt  = id_rt;
                r.rw  = id_regwrite;
                r.ld  = id_is_load;
                r.st  = id_is_store;
                r.adv = adv_cnt;
                rec_q.push_back(r);
            end
            while (rec_q.size() > 0 && adv_cnt - rec_q[0].adv > N_FWD) void'(rec_q.pop_front());
        end
        if (model_live) begin
            check("ex_fwd_a_model", int'(ex_fwd_a), exp_a);
            check("ex_fwd_b_model", int'(ex_fwd_b), exp_b);
            check("mem_store_fwd_model", int'(mem_store_fwd), exp_sf);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_rd       = '0;
        id_uses_rs  = 1'b0;
        id_uses_rt  = 1'b0;
        id_regwrite = 1'b0;
        id_is_load  = 1'b0;
        id_is_store = 1'b0;
        hold        = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rd, input logic rw, input logic ld, input logic st,
                         input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
        id_valid    = 1'b1;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        id_is_store = st;
        id_rs       = rs;
        id_uses_rs  = urs;
        id_rt       = rt;
        id_uses_rt  = urt;
        hold        = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    function automatic logic [4:0] rnd_reg();
        int v;
        v = $urandom_range(0, 5);
        return (v == 5) ? 5'd31 : 5'(v);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        check("reset_fwd_a", int'(ex_fwd_a), 0);
        check("reset_fwd_b", int'(ex_fwd_b), 0);
        check("reset_store_fwd", int'(mem_store_fwd), 0);
        check("reset_stall", int'(stall), 0);

        // forward distance 1, 2, 3
        instr(3, 1, 0, 0, 1, 0, 2, 0); tick();
        instr(8, 1, 0, 0, 3, 1, 0, 0); #1;
        check("dist1_stall", int'(stall), 0);
        tick();
        check("fwd_dist1", int'(ex_fwd_a), 1);
        drain();
        instr(3, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(7, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 3, 1, 0, 0); tick();
        check("fwd_dist2", int'(ex_fwd_a), 2);
        drain();
        instr(3, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(7, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(9, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 3, 1, 0, 0); tick();
        check("fwd_dist3", int'(ex_fwd_a), 0);

        // youngest producer wins
        drain();
        instr(3, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(3, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 0, 0, 3, 1); tick();
        check("youngest_b", int'(ex_fwd_b), 1);
        check("youngest_a_unused", int'(ex_fwd_a), 0);

        // load-use
        drain();
        instr(4, 1, 1, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 0, 0, 4, 1); #1;
        check("lu_stall_on", int'(stall), 1);
        tick();
        check("lu_stall_off", int'(stall), 0);
        check("lu_bubble_b", int'(ex_fwd_b), 0);
        tick();
        check("lu_fwd_b", int'(ex_fwd_b), 2);
        drain();
        instr(4, 1, 1, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 0, 0, 4, 0); #1;
        check("lu_unused_nostall", int'(stall), 0);

        // null register
        drain();
        instr(31, 1, 1, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 31, 1, 0, 0); #1;
        check("null_stall", int'(stall), 0);
        tick();
        check("null_sel", int'(ex_fwd_a), 0);

        // hold during a stall
        drain();
        instr(2, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(4, 1, 1, 0, 2, 1, 0, 0); tick();
        check("hold_pre_a", int'(ex_fwd_a), 1);
        instr(8, 1, 0, 0, 0, 0, 4, 1);
        hold = 1'b1; #1;
        check("hold_stall0", int'(stall), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_stall", int'(stall), 1);
            check("hold_fwd_a", int'(ex_fwd_a), 1);
        end
        hold = 1'b0;
        tick();
        check("hold_rel_stall", int'(stall), 0);
        check("hold_rel_a", int'(ex_fwd_a), 0);
        tick();
        check("hold_rel_b", int'(ex_fwd_b), 2);

        // reset mid-stream
        drain();
        instr(6, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(8, 1, 0, 0, 6, 1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_a", int'(ex_fwd_a), 0);
        check("rst_mid_stall", int'(stall), 0);
        tick();
        check("rst_consumer_a", int'(ex_fwd_a), 0);

        // store-data forward
        drain();
        instr(5, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(0, 0, 0, 1, 1, 1, 5, 1); tick();
        idle(); tick();
        check("store_fwd_on", int'(mem_store_fwd), 1);
        tick();
        check("store_fwd_after", int'(mem_store_fwd), 0);
        drain();
        instr(5, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(7, 1, 0, 0, 0, 0, 0, 0); tick();
        instr(0, 0, 0, 1, 1, 1, 5, 1); tick();
        idle(); tick();
        check("store_fwd_gap", int'(mem_store_fwd), 0);

        // random traffic
        drain();
        for (int c = 0; c < 1500; c++) begin
            id_valid    = ($urandom_range(0, 99) < 85);
            id_rs       = rnd_reg();
            id_rt       = rnd_reg();
            id_rd       = rnd_reg();
            id_uses_rs  = $urandom_range(0, 1);
            id_uses_rt  = $urandom_range(0, 1);
            id_regwrite = ($urandom_range(0, 99) < 75);
            id_is_load  = ($urandom_range(0, 99) < 30);
            id_is_store = ($urandom_range(0, 99) < 20);
            hold        = ($urandom_range(0, 99) < 10);
            flush       = ($urandom_range(0, 99) < 10);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
